// File: rtl/weighted_sum_sequencer.sv
// Time-multiplexed weighted-sum engine: one shared multiplier walks the captured
// weight/input pairs, accumulates the products and hands the sum over valid/ready.
module weighted_sum_sequencer #(
    parameter  int NUM_INPUTS = 2,
    parameter  int BIT_LENGTH = 4,
    localparam int ACC_W      = 2*BIT_LENGTH + $clog2(NUM_INPUTS) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  abort,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] weights,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] inputs,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_W-1:0]                      out_sum,
    output logic                                  busy
);

    localparam int PROD_W = 2*BIT_LENGTH;
    localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

    state_t                 state_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [PROD_W-1:0]      prod_reg;
    logic                   prod_v_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic                   busy_reg;
    logic [ACC_W-1:0]       out_sum_reg;
    logic [BIT_LENGTH-1:0]  w_reg [NUM_INPUTS];
    logic [BIT_LENGTH-1:0]  x_reg [NUM_INPUTS];

    logic                   accept;
    logic [BIT_LENGTH-1:0]  w_sel;
    logic [BIT_LENGTH-1:0]  x_sel;
    logic [PROD_W-1:0]      prod_next;
    logic [ACC_W-1:0]       acc_next;

    // in_ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept    = in_valid && in_ready_reg && !abort;
    assign w_sel     = w_reg[idx_reg];
    assign x_sel     = x_reg[idx_reg];
    assign prod_next = PROD_W'(w_sel) * PROD_W'(x_sel);
    assign acc_next  = prod_v_reg ? (acc_reg + ACC_W'(prod_reg)) : acc_reg;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_capture
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_reg[gi] <= '0;
                    x_reg[gi] <= '0;
                end else if (accept) begin
                    w_reg[gi] <= weights[gi];
                    x_reg[gi] <= inputs[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            busy_reg      <= 1'b0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            prod_reg      <= '0;
            prod_v_reg    <= 1'b0;
        end else if (abort && state_reg != IDLE) begin
            // Drop the in-flight vector; out_sum keeps the last delivered result.
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            idx_reg       <= '0;
            prod_v_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        idx_reg      <= '0;
                        acc_reg      <= '0;
                        prod_v_reg   <= 1'b0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= MAC;
                    end
                end
                MAC: begin
                    // Product of pair idx lands in acc one cycle later (pipelined).
                    prod_reg   <= prod_next;
                    prod_v_reg <= 1'b1;
                    acc_reg    <= acc_next;
                    idx_reg    <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    out_sum_reg   <= acc_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_weighted_sum_sequencer.sv
// Randomized bench for weighted_sum_sequencer: a 2-pair and a 4-pair instance
// checked against a plain dot-product model with handshake/latency expectations.
module tb_weighted_sum_sequencer;

    typedef logic [1:0][3:0] vec2_t;
    typedef logic [3:0][3:0] vec4_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    vec2_t       weights = '0, inputs = '0;
    logic [9:0]  out_sum;

    logic        abort4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4, busy4;
    vec4_t       weights4 = '0, inputs4 = '0;
    logic [10:0] out_sum4;

    int checks = 0;
    int failures = 0;
    int last_sum = 0;

    always #5 clk = ~clk;

    weighted_sum_sequencer #(.NUM_INPUTS(2), .BIT_LENGTH(4)) dut (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .weights(weights), .inputs(inputs), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    weighted_sum_sequencer #(.NUM_INPUTS(4), .BIT_LENGTH(4)) dut4 (
        .clk(clk), .rst(rst), .abort(abort4), .in_valid(in_valid4), .in_ready(in_ready4),
        .weights(weights4), .inputs(inputs4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .busy(busy4)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dot2(input vec2_t w, input vec2_t x);
        int s = 0;
        for (int i = 0; i < 2; i++) s += int'(w[i]) * int'(x[i]);
        return s;
    endfunction

    function automatic int dot4(input vec4_t w, input vec4_t x);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(w[i]) * int'(x[i]);
        return s;
    endfunction

    // Caller is positioned 1 time unit after a rising edge with the DUT idle.
    task automatic send2(input vec2_t w, input vec2_t x, input int hold, input bit noise);
        int exp_sum;
        int lat;
        exp_sum = dot2(w, x);
        weights = w; inputs = x; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        if (noise) begin
            weights = vec2_t'($urandom);
            inputs  = vec2_t'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        check("in_ready_busy", in_ready, 0);
        check("busy_high", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency2", lat, 3);
        check("sum2", out_sum, exp_sum);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, exp_sum);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        last_sum = exp_sum;
        $display("tx2 w=%h x=%h sum=%0d exp=%0d lat=%0d hold=%0d noise=%0d",
                 w, x, out_sum, exp_sum, lat, hold, noise);
    endtask

    task automatic send4(input vec4_t w, input vec4_t x);
        int exp_sum;
        int lat;
        exp_sum = dot4(w, x);
        weights4 = w; inputs4 = x; in_valid4 = 1'b1;
        check("in_ready4_idle", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency4", lat, 5);
        check("sum4", out_sum4, exp_sum);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("release4_valid", out_valid4, 0);
        $display("tx4 w=%h x=%h sum=%0d exp=%0d lat=%0d", w, x, out_sum4, exp_sum, lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum4", out_sum4, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: basic vector, all-max on the 4-pair unit, back-pressure, in_valid noise.
        send2({4'd3, 4'd5}, {4'd2, 4'd4}, 0, 1'b0);
        send4({4{4'd15}}, {4{4'd15}});
        send2({4'd15, 4'd15}, {4'd15, 4'd15}, 10, 1'b0);
        send2({4'd7, 4'd1}, {4'd2, 4'd9}, 0, 1'b1);

        // Abort in the second MAC cycle: result discarded, out_sum unchanged.
        weights = {4'd9, 4'd9}; inputs = {4'd9, 4'd9}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_sum_kept", out_sum, last_sum);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        send2({4'd1, 4'd1}, {4'd7, 4'd9}, 0, 1'b0);

        // Abort while idle outranks in_valid.
        weights = {4'd2, 4'd2}; inputs = {4'd2, 4'd2}; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_in_ready", in_ready, 1);
        repeat (4) begin
            @(posedge clk); #1;
            check("idle_abort_no_valid", out_valid, 0);
        end

        // Abort while DONE drops out_valid without consumer handshake.
        weights = {4'd4, 4'd3}; inputs = {4'd5, 4'd6}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_valid", out_valid, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("done_abort_valid", out_valid, 0);
        check("done_abort_busy", busy, 0);
        check("done_abort_sum", out_sum, 38);
        $display("abort in DONE sum=%0d", out_sum);

        // Reset during DRAIN clears everything.
        weights = {4'd6, 4'd6}; inputs = {4'd6, 4'd6}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("drain_rst_valid", out_valid, 0);
        check("drain_rst_sum", out_sum, 0);
        check("drain_rst_in_ready", in_ready, 1);
        check("drain_rst_busy", busy, 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("drain_rst_no_valid", out_valid, 0);
        end

        // Randomized traffic on both instances.
        for (int n = 0; n < 16; n++) begin
            send2(vec2_t'($urandom), vec2_t'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 4; n++) begin
            send4(vec4_t'($urandom), vec4_t'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
